// File: rtl/coo_enc_hls_deadlock_ctrl.sv
// rtl/coo_enc_hls_deadlock_ctrl.sv - deadlock controller: persistence filter plus blocked-index report channel
// Optional cycle stamp of the declaration: COO_ENC_DEADLOCK_STAMP_EN
module coo_enc_hls_deadlock_ctrl #(
    parameter int NUM_MON = 4,
    parameter int THRESH  = 16,
    parameter int IDX_W   = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               clear,
    input  logic [NUM_MON-1:0] mon_block,
    output logic               deadlock,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [IDX_W-1:0]   report_idx,
    output logic               report_last
`ifdef COO_ENC_DEADLOCK_STAMP_EN
    ,
    output logic [31:0]        stamp
`endif
);

    localparam int CNT_W = $clog2(THRESH + 1);

    typedef enum logic [1:0] {IDLE, SUSPECT, REPORT, HOLD} state_t;

    state_t             state_q, state_d;
    logic [NUM_MON-1:0] snap_q, snap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               deadlock_q, deadlock_d;
    logic [IDX_W-1:0]   low_idx;
    logic               single_bit;
    logic [NUM_MON-1:0] snap_drop;

`ifdef COO_ENC_DEADLOCK_STAMP_EN
    logic [31:0] cyc_q, stamp_q, stamp_d;
`endif

    // snap & (snap-1) removes the lowest set bit, i.e. the entry being reported
    assign snap_drop  = snap_q & (snap_q - NUM_MON'(1));
    assign single_bit = (snap_q != '0) && (snap_drop == '0);

    always_comb begin
        low_idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (snap_q[i]) low_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        cnt_d      = cnt_q;
        deadlock_d = deadlock_q;
`ifdef COO_ENC_DEADLOCK_STAMP_EN
        stamp_d    = stamp_q;
`endif
        if (clear) begin
            state_d    = IDLE;
            snap_d     = '0;
            cnt_d      = '0;
            deadlock_d = 1'b0;
`ifdef COO_ENC_DEADLOCK_STAMP_EN
            stamp_d    = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    snap_d = '0;
                    cnt_d  = '0;
                    if (enable && (mon_block != '0)) begin
                        snap_d  = mon_block;
                        cnt_d   = CNT_W'(1);
                        state_d = SUSPECT;
                    end
                end
                SUSPECT: begin
                    if (!enable || (mon_block == '0)) begin
                        state_d = IDLE;
                        snap_d  = '0;
                        cnt_d   = '0;
                    end else if (mon_block != snap_q) begin
                        snap_d = mon_block;
                        cnt_d  = CNT_W'(1);
                    end else if (cnt_q == CNT_W'(THRESH - 1)) begin
                        state_d    = REPORT;
                        deadlock_d = 1'b1;
`ifdef COO_ENC_DEADLOCK_STAMP_EN
                        stamp_d    = cyc_q;
`endif
                    end else if (cnt_q < CNT_W'(THRESH)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                REPORT: begin
                    if (report_ready) begin
                        snap_d = snap_drop;
                        if (single_bit) state_d = HOLD;
                    end
                end
                HOLD: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            cnt_q      <= '0;
            deadlock_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            deadlock_q <= deadlock_d;
        end
    end

`ifdef COO_ENC_DEADLOCK_STAMP_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q   <= '0;
            stamp_q <= '0;
        end else begin
            cyc_q   <= cyc_q + 32'd1;
            stamp_q <= stamp_d;
        end
    end
    assign stamp = stamp_q;
`endif

    assign deadlock     = deadlock_q;
    assign report_valid = (state_q == REPORT);
    assign report_idx   = report_valid ? low_idx : '0;
    assign report_last  = report_valid && single_bit;

endmodule

// File: tb/tb_coo_enc_hls_deadlock_ctrl.sv
// tb/tb_coo_enc_hls_deadlock_ctrl.sv - scoreboard bench for coo_enc_hls_deadlock_ctrl
module tb_coo_enc_hls_deadlock_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] mon_block = 4'b0;
    logic       deadlock;
    logic       report_valid;
    logic       report_ready = 1'b0;
    logic [1:0] report_idx;
    logic       report_last;
`ifdef COO_ENC_DEADLOCK_STAMP_EN
    logic [31:0] stamp;
    int          edge_cnt;
    int          exp_stamp;
`endif

    typedef struct {
        logic [1:0] idx;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    coo_enc_hls_deadlock_ctrl #(.NUM_MON(4), .THRESH(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .clear        (clear),
        .mon_block    (mon_block),
        .deadlock     (deadlock),
        .report_valid (report_valid),
        .report_ready (report_ready),
        .report_idx   (report_idx),
        .report_last  (report_last)
`ifdef COO_ENC_DEADLOCK_STAMP_EN
        ,
        .stamp        (stamp)
`endif
    );

    always #5 clock = ~clock;

`ifdef COO_ENC_DEADLOCK_STAMP_EN
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [1:0] idx, input logic last);
        exp_t e;
        e.idx  = idx;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Holds a mask for the 15 samples that must not declare, then the 16th that must
    task automatic detect(input logic [3:0] mask, input string name);
        mon_block = mask;
        repeat (15) tick();
        check({name, "_pre_deadlock"}, deadlock, 0);
        check({name, "_pre_valid"}, report_valid, 0);
        tick();
        check({name, "_deadlock"}, deadlock, 1);
        check({name, "_valid"}, report_valid, 1);
    endtask

    // Monitor: every presented entry must match the scoreboard head; pop on handshake
    always @(negedge clock) begin
        if (reset_n && report_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_entry: got idx %0d last %0d expected none at %0t",
                         report_idx, report_last, $time);
            end else begin
                check("entry_idx", 32'(report_idx), 32'(exp_q[0].idx));
                check("entry_last", 32'(report_last), 32'(exp_q[0].last));
                if (report_ready && !clear) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (3) tick();
        check("rst_deadlock", deadlock, 0);
        check("rst_valid", report_valid, 0);
        check("rst_idx", 32'(report_idx), 0);
        check("rst_last", report_last, 0);
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (2) tick();

        // single blocked monitor, ready held high
        report_ready = 1'b1;
        push(2'd2, 1'b1);
        detect(4'b0100, "t1");
`ifdef COO_ENC_DEADLOCK_STAMP_EN
        exp_stamp = edge_cnt - 1;
        check("t1_stamp", stamp, 32'(exp_stamp));
`endif
        tick();
        check("t1_hold_valid", report_valid, 0);
        mon_block = 4'b0;
        repeat (3) tick();
        check("t1_hold_deadlock", deadlock, 1);
        check("t1_drained", exp_q.size(), 0);
        pulse_clear();
        check("t1_clr_deadlock", deadlock, 0);
        check("t1_clr_valid", report_valid, 0);
`ifdef COO_ENC_DEADLOCK_STAMP_EN
        check("t1_clr_stamp", stamp, 0);
`endif

        // transient stall one sample short of the window
        mon_block = 4'b0010;
        repeat (15) tick();
        mon_block = 4'b0;
        repeat (4) tick();
        check("t2_deadlock", deadlock, 0);
        check("t2_valid", report_valid, 0);

        // mask change restarts the window
        mon_block = 4'b0001;
        repeat (10) tick();
        push(2'd0, 1'b0);
        push(2'd3, 1'b1);
        detect(4'b1001, "t3");
        repeat (3) tick();
        check("t3_hold_valid", report_valid, 0);
        check("t3_drained", exp_q.size(), 0);
        mon_block = 4'b0;
        pulse_clear();

        // backpressure: ready 1,0,0,1,1
        report_ready = 1'b0;
        push(2'd0, 1'b0);
        push(2'd1, 1'b0);
        push(2'd3, 1'b1);
        detect(4'b1011, "t4");
        mon_block = 4'b0;
        report_ready = 1'b1; tick();
        report_ready = 1'b0; tick();
        check("t4_stall_idx", 32'(report_idx), 1);
        tick();
        check("t4_stall_valid", report_valid, 1);
        report_ready = 1'b1; tick();
        tick();
        check("t4_hold_valid", report_valid, 0);
        check("t4_hold_deadlock", deadlock, 1);
        check("t4_drained", exp_q.size(), 0);
        pulse_clear();
        check("t4_clr_deadlock", deadlock, 0);
        check("t4_clr_idx", 32'(report_idx), 0);

        // clear on the final window sample wins; window restarts afterward
        mon_block = 4'b0100;
        repeat (15) tick();
        pulse_clear();
        check("t5_clear_wins", deadlock, 0);
        report_ready = 1'b1;
        push(2'd2, 1'b1);
        detect(4'b0100, "t5");
        mon_block = 4'b0;
        repeat (2) tick();
        pulse_clear();

        // asynchronous reset mid-report
        report_ready = 1'b0;
        push(2'd1, 1'b0);
        push(2'd2, 1'b1);
        detect(4'b0110, "t6");
        mon_block = 4'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_deadlock", deadlock, 0);
        check("t6_rst_valid", report_valid, 0);
        check("t6_rst_idx", 32'(report_idx), 0);
        check("t6_rst_last", report_last, 0);
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("t6_post_deadlock", deadlock, 0);
        check("t6_post_valid", report_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
